wb_dma_de_burst: RTL and testbench
==================================

Name: wb_dma_de_burst

Overview:
Parametrised successor to the single-beat wb_dma DMA engine. It executes one channel transfer as a sequence of bursts. Each burst reads up to BURST words from the source into an internal buffer, then writes them to the destination. The block sits between the channel arbiter (start, CSR fields, pause/abort) and the master-0 bus interface. It writes the remaining size and the updated addresses back to the channel register file after every burst.

Parameters:
AW, 32, address width
DW, 32, data width (bytes per beat = DW/8; DW is 8, 16, 32 or 64)
TSZ_W, 12, transfer-size counter width (words)
BURST, 16, buffer depth / maximum burst in words (power of 2, at least 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
de_start  in  1  start pulse; sampled only in IDLE
chunk_sz  in  $clog2(BURST)  burst length; 0 means BURST
txsz  in  TSZ_W  words to move
adr0  in  AW  source address
adr1  in  AW  destination address
inc_src  in  1  increment source address per beat
inc_dst  in  1  increment destination address per beat
pause_req  in  1  pause request
dma_abort  in  1  abort request
m_req  out  1  bus request
m_we  out  1  1 = write beat
m_adr  out  AW  bus address
m_dout  out  DW  write data
m_din  in  DW  read data
m_ack  in  1  beat complete
busy  out  1  high when not in IDLE
paused  out  1  high in PAUSE
done  out  1  one-cycle completion pulse
abort_done  out  1  one-cycle abort pulse
de_txsz  out  TSZ_W  remaining-size write-back value
de_adr0  out  AW  source-address write-back value
de_adr1  out  AW  destination-address write-back value
de_txsz_we  out  1  write-back strobe
de_adr0_we  out  1  write-back strobe
de_adr1_we  out  1  write-back strobe

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE. All outputs are 0, including m_adr, m_dout and the de_* values. The buffer contents are don't-care. Reset asserted mid-burst drops m_req in the next cycle with no write-back.
- States: IDLE, READ, WRITE, UPDATE, PAUSE.
- IDLE, de_start=1:
  - Latch rem=txsz, sa=adr0, da=adr1.
  - Latch n = min(chunk_sz or BURST, txsz).
  - If txsz==0: done=1 next cycle, stay in IDLE, no bus activity, no write-back.
  - Otherwise go to READ; m_req is asserted in the cycle after de_start.
- Bus handshake:
  - m_req, m_we, m_adr and m_dout are held stable until m_ack=1.
  - A beat completes in the cycle where m_req and m_ack are both 1.
  - m_req may stay high into the next cycle with the next beat's address (back-to-back, one beat per cycle maximum).
  - m_ack with m_req=0 is ignored.
- READ:
  - Beat i (0..n-1) uses m_adr=sa and m_we=0.
  - On ack: buf[i]=m_din. If inc_src, sa += DW/8, wrapping modulo 2^AW.
  - After beat n-1 is acked, go to WRITE with i=0.
- WRITE:
  - Beat i uses m_adr=da, m_we=1, m_dout=buf[i].
  - On ack: if inc_dst, da += DW/8.
  - After beat n-1 is acked, go to UPDATE.
- UPDATE (one cycle):
  - rem -= n.
  - de_txsz=rem-n, de_adr0=sa, de_adr1=da, and all three *_we strobes pulse for exactly this cycle.
  - Next state:
    - rem-n==0: done=1 next cycle, go to IDLE.
    - else pause_req=1: go to PAUSE.
    - else go to READ, with n recomputed as min(chunk, rem-n).
- PAUSE:
  - paused=1, m_req=0.
  - When pause_req=0, go to READ next cycle with paused=0.
  - dma_abort=1 in PAUSE goes to IDLE and pulses abort_done; no write-back is issued.
- Abort:
  - dma_abort is registered.
  - In READ/WRITE the abort takes effect at the next beat boundary: either the ack of the outstanding beat, or immediately if m_req is low that cycle.
  - m_req then drops, an UPDATE-style write-back of the current sa/da/rem (rem not reduced for the partial burst) is issued, followed by abort_done=1 and IDLE.
  - A read-phase abort discards the buffer.
- Priority: abort > done > pause. pause_req is honoured only at burst boundaries. pause_req in IDLE is ignored.
- done and abort_done are never high in the same cycle. busy=0 only in IDLE.

Test Plan:
- Basic transfer: txsz=5, chunk_sz=4, adr0=0x100, adr1=0x200, inc both, m_ack every cycle -> read 0x100..0x10C, write 0x200..0x20C. Write-back de_txsz=1, de_adr0=0x110, de_adr1=0x210. Then 1 read at 0x110 and 1 write at 0x210. Write-back de_txsz=0, then a done pulse, for 2 UPDATE strobes total.
- Zero size and full burst: txsz=0 -> done one cycle after de_start, m_req never high. chunk_sz=0 with BURST=16 and txsz=16 -> exactly 16 reads then 16 writes.
- Wait states and fixed address: m_ack delayed 3 cycles per beat, inc_src=0 -> m_adr, m_we and m_dout stable while waiting; every read uses adr0. Written data equals read data in order.
- Pause: pause_req=1 during the first burst of txsz=8, chunk_sz=4 -> PAUSE entered after the first UPDATE with paused=1. Dropping pause_req -> READ resumes at adr0+16.
- Abort: dma_abort pulsed during write beat 2 of 4 while that beat is waiting for m_ack -> beat 2 completes on its ack, no further m_req, write-back of the current sa/da/rem, abort_done pulse, IDLE. Reset mid-READ -> all outputs 0 next cycle.
- Address wrap: adr1=0xFFFF_FFFC, 2 words -> second write at 0x0000_0000.

Source files
------------

// File: rtl/wb_dma_de_burst.sv
// rtl/wb_dma_de_burst.sv - burst DMA data engine: reads a chunk into a buffer, writes it out, writes back.
// One channel transfer runs as READ/WRITE bursts separated by a one-cycle UPDATE write-back.
module wb_dma_de_burst #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TSZ_W = 12,
  parameter int BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     de_start,
  input  logic [$clog2(BURST)-1:0] chunk_sz,
  input  logic [TSZ_W-1:0]         txsz,
  input  logic [AW-1:0]            adr0,
  input  logic [AW-1:0]            adr1,
  input  logic                     inc_src,
  input  logic                     inc_dst,
  input  logic                     pause_req,
  input  logic                     dma_abort,
  output logic                     m_req,
  output logic                     m_we,
  output logic [AW-1:0]            m_adr,
  output logic [DW-1:0]            m_dout,
  input  logic [DW-1:0]            m_din,
  input  logic                     m_ack,
  output logic                     busy,
  output logic                     paused,
  output logic                     done,
  output logic                     abort_done,
  output logic [TSZ_W-1:0]         de_txsz,
  output logic [AW-1:0]            de_adr0,
  output logic [AW-1:0]            de_adr1,
  output logic                     de_txsz_we,
  output logic                     de_adr0_we,
  output logic                     de_adr1_we
);

  localparam int BW = $clog2(BURST);
  localparam int CW = BW + 1;
  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_UPDATE, S_PAUSE} state_t;

  state_t            r_state, w_next;
  logic [AW-1:0]     r_sa, r_da;
  logic [TSZ_W-1:0]  r_rem;
  logic [CW-1:0]     r_n, r_chunk, r_idx;
  logic              r_full, r_abort_pend, r_done, r_abort_done;
  logic [DW-1:0]     r_buf [0:BURST-1];

  logic              w_beat, w_last;
  logic [TSZ_W-1:0]  w_rem_next;
  logic [CW-1:0]     w_start_chunk;

  function automatic logic [CW-1:0] f_min(input logic [CW-1:0] c, input logic [TSZ_W-1:0] r);
    if (r < TSZ_W'(c)) return CW'(r);
    return c;
  endfunction

  assign w_beat        = m_req & m_ack;
  assign w_last        = (r_idx == r_n - CW'(1));
  // A burst cut short by abort leaves the remaining size untouched.
  assign w_rem_next    = r_full ? r_rem - TSZ_W'(r_n) : r_rem;
  assign w_start_chunk = (chunk_sz == '0) ? CW'(BURST) : {1'b0, chunk_sz};

  assign m_req      = (r_state == S_READ) || (r_state == S_WRITE);
  assign m_we       = (r_state == S_WRITE);
  assign m_adr      = m_we ? r_da : ((r_state == S_READ) ? r_sa : '0);
  assign m_dout     = m_we ? r_buf[r_idx[BW-1:0]] : '0;
  assign busy       = (r_state != S_IDLE);
  assign paused     = (r_state == S_PAUSE);
  assign done       = r_done;
  assign abort_done = r_abort_done;
  assign de_txsz    = (r_state == S_UPDATE) ? w_rem_next : '0;
  assign de_adr0    = (r_state == S_UPDATE) ? r_sa : '0;
  assign de_adr1    = (r_state == S_UPDATE) ? r_da : '0;
  assign de_txsz_we = (r_state == S_UPDATE);
  assign de_adr0_we = (r_state == S_UPDATE);
  assign de_adr1_we = (r_state == S_UPDATE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (de_start && (txsz != '0)) w_next = S_READ;
      S_READ: begin
        if (w_beat && r_abort_pend) w_next = S_UPDATE;
        else if (w_beat && w_last)  w_next = S_WRITE;
      end
      S_WRITE:  if (w_beat && (w_last || r_abort_pend)) w_next = S_UPDATE;
      S_UPDATE: begin
        if (r_abort_pend)             w_next = S_IDLE;
        else if (w_rem_next == '0)    w_next = S_IDLE;
        else if (pause_req)           w_next = S_PAUSE;
        else                          w_next = S_READ;
      end
      S_PAUSE: begin
        if (r_abort_pend)    w_next = S_IDLE;
        else if (!pause_req) w_next = S_READ;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sa         <= '0;
      r_da         <= '0;
      r_rem        <= '0;
      r_n          <= '0;
      r_chunk      <= '0;
      r_idx        <= '0;
      r_full       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
      r_abort_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_done       <= 1'b0;
      r_abort_done <= 1'b0;
      r_abort_pend <= (r_state == S_IDLE) ? 1'b0 : (r_abort_pend | dma_abort);
      case (r_state)
        S_IDLE: begin
          if (de_start) begin
            r_rem   <= txsz;
            r_sa    <= adr0;
            r_da    <= adr1;
            r_chunk <= w_start_chunk;
            r_n     <= f_min(w_start_chunk, txsz);
            r_idx   <= '0;
            r_full  <= 1'b0;
            r_done  <= (txsz == '0);
          end
        end
        S_READ: begin
          if (w_beat) begin
            r_sa  <= r_sa + (inc_src ? STEP : '0);
            r_idx <= w_last ? '0 : r_idx + CW'(1);
          end
        end
        S_WRITE: begin
          if (w_beat) begin
            r_da   <= r_da + (inc_dst ? STEP : '0);
            r_idx  <= r_idx + CW'(1);
            r_full <= w_last;
          end
        end
        S_UPDATE: begin
          r_rem  <= w_rem_next;
          r_n    <= f_min(r_chunk, w_rem_next);
          r_idx  <= '0;
          r_full <= 1'b0;
          if (r_abort_pend)           r_abort_done <= 1'b1;
          else if (w_rem_next == '0)  r_done       <= 1'b1;
        end
        S_PAUSE: begin
          if (r_abort_pend) r_abort_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_READ) && w_beat) r_buf[r_idx[BW-1:0]] <= m_din;
  end

endmodule

// File: tb/tb_wb_dma_de_burst.sv
// tb/tb_wb_dma_de_burst.sv - directed vector bench for wb_dma_de_burst.
// A per-cycle responder acks beats after a set delay and checks addresses, data order and stability.
module tb_wb_dma_de_burst;

  logic        clk = 1'b0;
  logic        rst, de_start, inc_src, inc_dst, pause_req, dma_abort, m_ack;
  logic [3:0]  chunk_sz;
  logic [11:0] txsz;
  logic [31:0] adr0, adr1, m_din;
  logic        m_req, m_we, busy, paused, done, abort_done;
  logic        de_txsz_we, de_adr0_we, de_adr1_we;
  logic [31:0] m_adr, m_dout, de_adr0, de_adr1;
  logic [11:0] de_txsz;

  always #5 clk = ~clk;

  wb_dma_de_burst dut (
    .clk(clk), .rst(rst), .de_start(de_start), .chunk_sz(chunk_sz), .txsz(txsz),
    .adr0(adr0), .adr1(adr1), .inc_src(inc_src), .inc_dst(inc_dst),
    .pause_req(pause_req), .dma_abort(dma_abort),
    .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_dout(m_dout), .m_din(m_din), .m_ack(m_ack),
    .busy(busy), .paused(paused), .done(done), .abort_done(abort_done),
    .de_txsz(de_txsz), .de_adr0(de_adr0), .de_adr1(de_adr1),
    .de_txsz_we(de_txsz_we), .de_adr0_we(de_adr0_we), .de_adr1_we(de_adr1_we)
  );

  typedef struct {
    int          txsz, chunk, dly;
    logic [31:0] a0, a1;
    bit          isrc, idst;
    int          nbeats, nupd, done_cyc;
    logic [11:0] f_tx, l_tx;
    logic [31:0] f_a0, f_a1, l_a0, l_a1;
  } vec_t;

  vec_t vt [6];

  int n_chk = 0, n_err = 0;
  int cyc, nrd, nwr, nupd, nreq, npause, got_done, got_abort, done_cyc;
  int wcnt, ack_dly, addr_err, data_err, stab_err, both_err;
  logic [31:0] xa0, xa1, p_adr, p_dout;
  bit          xis, xid, prev_wait, p_we;
  logic [11:0] f_tx, l_tx;
  logic [31:0] f_a0, f_a1, l_a0, l_a1;
  logic [31:0] rdq [$];

  function automatic vec_t mk(int tx, int ch, int d, logic [31:0] a0, logic [31:0] a1, bit is, bit id,
                              int nb, int nu, int dc, logic [11:0] ftx, logic [31:0] fa0, logic [31:0] fa1,
                              logic [11:0] ltx, logic [31:0] la0, logic [31:0] la1);
    vec_t v;
    v.txsz = tx; v.chunk = ch; v.dly = d; v.a0 = a0; v.a1 = a1; v.isrc = is; v.idst = id;
    v.nbeats = nb; v.nupd = nu; v.done_cyc = dc;
    v.f_tx = ftx; v.f_a0 = fa0; v.f_a1 = fa1; v.l_tx = ltx; v.l_a0 = la0; v.l_a1 = la1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{m_req, m_we, m_adr, m_dout, busy, paused, done, abort_done,
             de_txsz, de_adr0, de_adr1, de_txsz_we, de_adr0_we, de_adr1_we};
  endfunction

  task automatic clear_stats();
    cyc = 0; nrd = 0; nwr = 0; nupd = 0; nreq = 0; npause = 0; got_done = 0; got_abort = 0;
    done_cyc = -1; wcnt = 0; addr_err = 0; data_err = 0; stab_err = 0; both_err = 0;
    prev_wait = 0; f_tx = 0; l_tx = 0; f_a0 = 0; f_a1 = 0; l_a0 = 0; l_a1 = 0;
    rdq.delete();
  endtask

  // One clock: observe outputs just after the edge, then drive this cycle's response.
  task automatic tick();
    logic [31:0] ea;
    @(posedge clk); #1;
    cyc++;
    de_start = 1'b0;
    dma_abort = 1'b0;
    if (done && abort_done) both_err++;
    if (de_txsz_we) begin
      if (nupd == 0) begin f_tx = de_txsz; f_a0 = de_adr0; f_a1 = de_adr1; end
      l_tx = de_txsz; l_a0 = de_adr0; l_a1 = de_adr1;
      nupd++;
      if (!(de_adr0_we && de_adr1_we)) both_err++;
    end
    if (done) begin got_done++; done_cyc = cyc; end
    if (abort_done) got_abort++;
    if (paused) npause++;
    if (prev_wait && (!m_req || m_adr != p_adr || m_we != p_we || m_dout != p_dout)) stab_err++;
    m_ack = 1'b0;
    if (m_req) begin
      nreq++;
      if (!m_we) ea = xa0 + (xis ? 32'(nrd * 4) : 32'd0);
      else       ea = xa1 + (xid ? 32'(nwr * 4) : 32'd0);
      if (m_adr != ea) addr_err++;
      m_din = 32'hC0DE_0000 + 32'(nrd);
      if (wcnt == ack_dly) begin
        m_ack = 1'b1;
        wcnt = 0;
        if (!m_we) begin
          rdq.push_back(m_din);
          nrd++;
        end else begin
          if (nwr >= rdq.size() || m_dout != rdq[nwr]) data_err++;
          nwr++;
        end
      end else begin
        wcnt++;
      end
    end
    prev_wait = m_req && !m_ack;
    p_adr = m_adr; p_we = m_we; p_dout = m_dout;
  endtask

  task automatic start(input int tx, input int ch, input logic [31:0] a0, input logic [31:0] a1,
                       input bit is, input bit id, input int d);
    clear_stats();
    xa0 = a0; xa1 = a1; xis = is; xid = id; ack_dly = d;
    txsz = 12'(tx); chunk_sz = 4'(ch); adr0 = a0; adr1 = a1; inc_src = is; inc_dst = id;
    de_start = 1'b1;
  endtask

  task automatic run_to_end();
    while (got_done == 0 && got_abort == 0 && cyc < 3000) tick();
    tick();
  endtask

  initial begin
    vt[0] = mk(5, 4, 0, 32'h100, 32'h200, 1, 1, 5, 2, 13, 12'd1, 32'h110, 32'h210, 12'd0, 32'h114, 32'h214);
    vt[1] = mk(0, 4, 0, 32'h100, 32'h200, 1, 1, 0, 0, 1, 12'd0, 32'h0, 32'h0, 12'd0, 32'h0, 32'h0);
    vt[2] = mk(16, 0, 0, 32'h1000, 32'h2000, 1, 1, 16, 1, 34, 12'd0, 32'h1040, 32'h2040, 12'd0, 32'h1040, 32'h2040);
    vt[3] = mk(3, 2, 3, 32'h300, 32'h400, 0, 1, 3, 2, 27, 12'd1, 32'h300, 32'h408, 12'd0, 32'h300, 32'h40C);
    vt[4] = mk(2, 0, 0, 32'h10, 32'hFFFF_FFFC, 1, 1, 2, 1, 6, 12'd0, 32'h18, 32'h4, 12'd0, 32'h18, 32'h4);
    vt[5] = mk(7, 3, 1, 32'h40, 32'h80, 1, 1, 7, 3, 32, 12'd4, 32'h4C, 32'h8C, 12'd0, 32'h5C, 32'h9C);

    rst = 1'b1; de_start = 0; chunk_sz = 0; txsz = 0; adr0 = 0; adr1 = 0; inc_src = 0; inc_dst = 0;
    pause_req = 0; dma_abort = 0; m_ack = 0; m_din = 0;
    clear_stats(); ack_dly = 0;
    repeat (3) tick();
    chk("reset_outputs", any_out(), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      start(vt[i].txsz, vt[i].chunk, vt[i].a0, vt[i].a1, vt[i].isrc, vt[i].idst, vt[i].dly);
      run_to_end();
      chk($sformatf("v%0d_reads", i), nrd, vt[i].nbeats);
      chk($sformatf("v%0d_writes", i), nwr, vt[i].nbeats);
      chk($sformatf("v%0d_req_cycles", i), nreq, 2 * vt[i].nbeats * (vt[i].dly + 1));
      chk($sformatf("v%0d_updates", i), nupd, vt[i].nupd);
      chk($sformatf("v%0d_done_once", i), got_done, 1);
      chk($sformatf("v%0d_done_cycle", i), done_cyc, vt[i].done_cyc);
      chk($sformatf("v%0d_errs", i), {addr_err[15:0], data_err[15:0], stab_err[15:0], both_err[15:0]}, 0);
      if (vt[i].nupd > 0) begin
        chk($sformatf("v%0d_first_wb", i), {f_tx, f_a0, f_a1}, {vt[i].f_tx, vt[i].f_a0, vt[i].f_a1});
        chk($sformatf("v%0d_last_wb", i), {l_tx, l_a0, l_a1}, {vt[i].l_tx, vt[i].l_a0, vt[i].l_a1});
      end
    end

    // Pause after the first burst, resume at adr0+16.
    pause_req = 1'b1;
    start(8, 4, 32'h100, 32'h200, 1, 1, 0);
    while (nupd == 0 && cyc < 200) tick();
    chk("pause_first_wb", {f_tx, f_a0, f_a1}, {12'd4, 32'h110, 32'h210});
    tick();
    chk("pause_entered", {paused, m_req, busy}, 3'b101);
    tick(); tick();
    chk("pause_held", {npause[7:0], m_req}, {8'd3, 1'b0});
    pause_req = 1'b0;
    tick();
    chk("pause_resume", {paused, m_req, m_we, m_adr}, {1'b0, 1'b1, 1'b0, 32'h110});
    run_to_end();
    chk("pause_total", {nrd[7:0], nwr[7:0], nupd[7:0], got_done[7:0]}, {8'd8, 8'd8, 8'd2, 8'd1});
    chk("pause_errs", {addr_err[15:0], data_err[15:0], stab_err[15:0]}, 0);

    // Abort while write beat 2 of 0..3 waits for its ack.
    start(4, 4, 32'h100, 32'h200, 1, 1, 3);
    while (!(m_req && m_we && nwr == 2) && cyc < 300) tick();
    dma_abort = 1'b1;
    run_to_end();
    repeat (3) tick();
    chk("abort_beats", {nrd[7:0], nwr[7:0]}, {8'd4, 8'd3});
    chk("abort_wb", {nupd[7:0], f_tx, f_a0, f_a1}, {8'd1, 12'd4, 32'h110, 32'h20C});
    chk("abort_pulse", {got_abort[7:0], got_done[7:0], busy}, {8'd1, 8'd0, 1'b0});
    chk("abort_errs", {addr_err[15:0], data_err[15:0], stab_err[15:0], both_err[15:0]}, 0);

    // Reset in the middle of a read burst.
    start(16, 0, 32'h500, 32'h600, 1, 1, 2);
    repeat (5) tick();
    chk("midread_busy", {busy, m_req, m_we}, 3'b110);
    rst = 1'b1;
    tick();
    chk("midread_reset", any_out(), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("midread_quiet", {nupd[7:0], got_done[7:0], busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
